// File: rtl/sram_controller.sv
// sram_controller: single-transaction responder between the cache controller and
// an external 256K x 16 asynchronous SRAM. Reads fetch an aligned 64-bit line as
// four halfword beats; writes store one 32-bit word as two halfword beats.
//
// Handshake: a request (rdEn or wrEn) is accepted on the first rising edge at
// which the controller is IDLE and the request is high; address and writeData
// are latched on that edge and all inputs are ignored until the transaction ends.
// ready is high for exactly one cycle (DONE) when the transaction completes, and
// also while IDLE with no request pending. A request still high in the cycle
// after DONE is taken as a new transaction.
module sram_controller #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [63:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(ACCESS_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  beat;
    logic [3:0]  wait_cnt;
    logic [16:0] addr_q;      // byte address bits [18:2]
    logic [31:0] data_q;
    logic        beat_end;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_addr_bits;

    assign beat_end = (wait_cnt == LAST_WAIT);

    // Byte-address bits outside [18:2] never reach the SRAM.
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: write wins over read when both are requested.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wrEn)      state_nxt = WRITE;
                else if (rdEn) state_nxt = READ;
            end
            READ:    if (beat_end && beat == 2'd3) state_nxt = DONE;
            WRITE:   if (beat_end && beat == 2'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat/wait counters and request latches; counters restart on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            beat     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    beat     <= '0;
                    if (rdEn || wrEn) begin
                        addr_q <= address[18:2];
                        data_q <= writeData;
                    end
                end
                READ, WRITE: begin
                    if (beat_end) begin
                        wait_cnt <= '0;
                        beat     <= beat + 2'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture each read halfword on the last cycle of its beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) readData <= '0;
        else if (state == READ && beat_end) readData[{beat, 4'b0000} +: 16] <= SRAM_DQ;
    end

    // SRAM address, write strobe and data drive, decoded from the current beat.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            READ:  SRAM_ADDR = {addr_q[16:1], beat};
            WRITE: begin
                SRAM_ADDR = {addr_q, beat[0]};
                SRAM_WE_N = 1'b0;
                dq_oe     = 1'b1;
                dq_out    = beat[0] ? data_q[31:16] : data_q[15:0];
            end
            default: ;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign ready     = (state == IDLE && !rdEn && !wrEn) || (state == DONE);
    assign dbg_state = state;

endmodule
